alu_requester: RTL and testbench

Initiator-side driver for the ALU start/done operand interface. It accepts operation commands on a valid/ready stream and drives one operation at a time onto the ALU's `start`/`op`/`A`/`B` inputs. It waits for `done` (or a watchdog timeout) and buffers results in order on a valid/ready response stream. It sits between a command source (sequencer, CPU port) and the ALU, and it owns all start-hold and done-drain rules.

---
 rtl/alu_req_pkg.sv | 28 ++
 rtl/alu_rsp_fifo.sv | 56 +++++
 rtl/alu_requester.sv | 141 ++++++++++++++
 tb/tb_alu_requester.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_pkg.sv
// rtl/alu_req_pkg.sv - shared types and widths for the ALU requester
package alu_req_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
  } req_state_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [OP_W-1:0]  op;
    logic             timeout;
  } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - in-order response FIFO with full/empty/count
module alu_rsp_fifo
  import alu_req_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rsp_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/alu_requester.sv
// rtl/alu_requester.sv - issues one ALU op at a time and queues results in order
module alu_requester
  import alu_req_pkg::*;
#(
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_timeout,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              busy
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam int              CNT_W   = $clog2(RSP_DEPTH) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  req_state_e       state;
  req_state_e       state_nxt;
  logic [WD_W-1:0]  wd_cnt;
  logic             push;
  rsp_t             push_data;
  rsp_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             accept;
  logic             issue;
  logic             finish;

  assign cmd_ready = (state == ST_IDLE) && !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op == NO_OP) begin
            push = 1'b1;
          end else begin
            issue     = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A done arriving on the watchdog's last cycle still wins.
        if (alu_done) begin
          push             = 1'b1;
          push_data.result = alu_result;
          push_data.op     = alu_op;
          finish           = 1'b1;
          state_nxt        = ST_DRAIN;
        end else if (wd_cnt == WD_LAST) begin
          push              = 1'b1;
          push_data.op      = alu_op;
          push_data.timeout = 1'b1;
          finish            = 1'b1;
          state_nxt         = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!alu_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_start <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      wd_cnt    <= '0;
    end else if (issue) begin
      alu_start <= 1'b1;
      alu_op    <= cmd_op;
      alu_a     <= cmd_a;
      alu_b     <= cmd_b;
      wd_cnt    <= '0;
    end else if (finish) begin
      alu_start <= 1'b0;
    end else if (state == ST_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields read as zero when nothing is queued, so reset shows a clean bus.
  assign rsp_valid   = (fifo_count != '0);
  assign rsp_result  = fifo_empty ? '0 : fifo_head.result;
  assign rsp_op      = fifo_empty ? '0 : fifo_head.op;
  assign rsp_timeout = fifo_empty ? 1'b0 : fifo_head.timeout;

endmodule

// File: tb/tb_alu_requester.sv
// tb/tb_alu_requester.sv - scoreboard bench for alu_requester with a behavioural ALU
module tb_alu_requester;
  import alu_req_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   npop = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;

  always #5 clk = ~clk;

  alu_requester #(.RSP_DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_timeout(rsp_timeout),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  // ALU: single-cycle ops pulse done one edge after start rises, mul three edges later.
  logic       alu_hang = 1'b0;
  logic       start_d;
  logic [1:0] mcnt;
  logic [15:0] mres;
  always @(posedge clk) begin
    if (reset) begin
      start_d <= 1'b0; mcnt <= '0; alu_done <= 1'b0; alu_result <= '0; mres <= '0;
    end else begin
      start_d  <= alu_start;
      alu_done <= 1'b0;
      if (alu_start && !start_d && !alu_hang) begin
        if (alu_op[2]) begin
          mcnt <= 2'd3;
          mres <= 16'(alu_a) * 16'(alu_b);
        end else begin
          alu_done <= 1'b1;
          case (alu_op[1:0])
            2'b01:   alu_result <= 16'(alu_a) + 16'(alu_b);
            2'b10:   alu_result <= 16'(alu_a & alu_b);
            2'b11:   alu_result <= 16'(alu_a ^ alu_b);
            default: alu_result <= '0;
          endcase
        end
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 2'd1;
        if (mcnt == 2'd1) begin
          alu_done   <= 1'b1;
          alu_result <= mres;
        end
      end
    end
  end

  function automatic rsp_t exp_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    r.op = op;
    r.timeout = 1'b0;
    case (op)
      3'b000:  r.result = 16'h0000;
      3'b001:  r.result = {8'h00, a} + {8'h00, b};
      3'b010:  r.result = {8'h00, a & b};
      3'b011:  r.result = {8'h00, a ^ b};
      default: r.result = {8'h00, a} * {8'h00, b};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got result=%h op=%b timeout=%b, required no response", rsp_result, rsp_op, rsp_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        npop++;
        if ({rsp_result, rsp_op, rsp_timeout} !== mon_e) begin
          errors++;
          $display("FAIL rsp_data: got result=%h op=%b timeout=%b, required result=%h op=%b timeout=%b",
                   rsp_result, rsp_op, rsp_timeout, mon_e.result, mon_e.op, mon_e.timeout);
        end
      end
    end
  end

  // Returns just after the accept edge (edge 0).
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit   acc = 1'b0;
    rsp_t e;
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1'b1; break; end
    end
    if (acc) begin
      if (alu_hang && op != 3'b000) begin
        e.result = 16'h0000; e.op = op; e.timeout = 1'b1;
      end else begin
        e = exp_rsp(op, a, b);
      end
      exp_q.push_back(e);
      @(posedge clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready=0 for 60 cycles, required 1");
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if ({rsp_result, rsp_op, rsp_timeout} !== 20'h0) begin errors++; $display("FAIL reset_rsp: got %h, required 0", {rsp_result, rsp_op, rsp_timeout}); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset_alu_start: got %b, required 0", alu_start); end
    checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL reset_alu_bus: got %h, required 0", {alu_op, alu_a, alu_b}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_add();
    logic [7:0] sm = 8'b0000_0011, vm = 8'b0000_0100, rm = 8'b0001_1000;
    rsp_ready = 1'b1;
    issue(3'b001, 8'hFF, 8'h01);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (alu_start !== sm[k]) begin errors++; $display("FAIL add_start k=%0d: got %b, required %b", k, alu_start, sm[k]); end
      checks++; if (rsp_valid !== vm[k]) begin errors++; $display("FAIL add_valid k=%0d: got %b, required %b", k, rsp_valid, vm[k]); end
      checks++; if (cmd_ready !== rm[k]) begin errors++; $display("FAIL add_ready k=%0d: got %b, required %b", k, cmd_ready, rm[k]); end
      if (k < 2) begin
        checks++; if ({alu_op, alu_a, alu_b} !== {3'b001, 8'hFF, 8'h01}) begin errors++; $display("FAIL add_hold k=%0d: got %h, required %h", k, {alu_op, alu_a, alu_b}, {3'b001, 8'hFF, 8'h01}); end
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] sm = 8'b0001_1111, vm = 8'b0010_0000, rm = 8'b1100_0000;
    rsp_ready = 1'b1;
    issue(3'b100, 8'hFF, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (alu_start !== sm[k]) begin errors++; $display("FAIL mul_start k=%0d: got %b, required %b", k, alu_start, sm[k]); end
      checks++; if (rsp_valid !== vm[k]) begin errors++; $display("FAIL mul_valid k=%0d: got %b, required %b", k, rsp_valid, vm[k]); end
      checks++; if (cmd_ready !== rm[k]) begin errors++; $display("FAIL mul_ready k=%0d: got %b, required %b", k, cmd_ready, rm[k]); end
    end
  endtask

  task automatic test_noop_xor();
    rsp_ready = 1'b1;
    issue(3'b000, 8'h12, 8'h34);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL noop_valid: got %b, required 1", rsp_valid); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL noop_start: got %b, required 0", alu_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy: got %b, required 0", busy); end
    issue(3'b011, 8'hF0, 8'h3C);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL noop_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] av [5] = '{8'hF0, 8'hAA, 8'hFF, 8'h55, 8'hC3};
    logic [7:0] bv [5] = '{8'h3C, 8'h0F, 8'h81, 8'hAA, 8'h3F};
    int hi = 0;
    int pop0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(3'b010, av[i], bv[i]);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cmd_ready) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL b2b_full_ready: got %0d ready cycles, required 0", hi); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_full_valid: got %b, required 1", rsp_valid); end
    pop0 = npop;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    checks++; if (npop != pop0 + 1) begin errors++; $display("FAIL b2b_single_pop: got %0d pops, required %0d", npop - pop0, 1); end
    issue(3'b010, av[4], bv[4]);
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    rsp_ready = 1'b1;
    alu_hang = 1'b1;
    issue(3'b001, 8'h11, 8'h22);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      checks++; if (alu_start !== (k < 16)) begin errors++; $display("FAIL to_start k=%0d: got %b, required %b", k, alu_start, k < 16); end
      checks++; if (rsp_valid !== (k == 16)) begin errors++; $display("FAIL to_valid k=%0d: got %b, required %b", k, rsp_valid, k == 16); end
      checks++; if (cmd_ready !== (k >= 17)) begin errors++; $display("FAIL to_ready k=%0d: got %b, required %b", k, cmd_ready, k >= 17); end
      if (k == 16) begin
        checks++; if (rsp_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b, required 1", rsp_timeout); end
      end
    end
    alu_hang = 1'b0;
    issue(3'b101, 8'h12, 8'h34);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_recover: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int pop0;
    rsp_ready = 1'b1;
    issue(3'b100, 8'h07, 8'h09);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    void'(exp_q.pop_back());
    pop0 = npop;
    @(negedge clk);
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b, required 0", alu_start); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL rmid_bus: got %h, required 0", {alu_op, alu_a, alu_b}); end
    repeat (10) @(negedge clk);
    checks++; if (npop != pop0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp: got %0d pops valid=%b, required 0 pops valid=0", npop - pop0, rsp_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_noop_xor();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
